// File: rtl/fod_ctrl_if.sv
// Control/status bundle of the FOD digital controller.
// The bench drives the control inputs through the master modport; the
// controller owns the slave side and drives the per-edge divider, retimer
// and DTC words back.
interface fod_ctrl_if #(
   parameter int WI       = 6,
   parameter int WF       = 16,
   parameter int WF_PHASE = 24
);
   // Control inputs (sampled on every FOD output edge)
   logic                DSM_EN;
   logic [WI+WF-1:0]    FCW_FOD;
   logic [2:0]          PHE;
   logic                PCALI_EN;
   logic [4:0]          PCALI_KS;
   logic [9:0]          PHASE_CTRL;
   logic                RT_EN;
   logic                DTCCALI_EN;
   logic [4:0]          KB;
   logic [9:0]          KDTCB_INIT;

   // Per-edge control words for the next output edge
   logic [WI-1:0]       MMD_DCW;
   logic                RT_DCW;
   logic [9:0]          DTC_DCW;
   logic [WF_PHASE-1:0] NCO_PHASE;

   modport master (
      output DSM_EN, FCW_FOD, PHE, PCALI_EN, PCALI_KS, PHASE_CTRL,
             RT_EN, DTCCALI_EN, KB, KDTCB_INIT,
      input  MMD_DCW, RT_DCW, DTC_DCW, NCO_PHASE
   );

   modport slave (
      input  DSM_EN, FCW_FOD, PHE, PCALI_EN, PCALI_KS, PHASE_CTRL,
             RT_EN, DTCCALI_EN, KB, KDTCB_INIT,
      output MMD_DCW, RT_DCW, DTC_DCW, NCO_PHASE
   );
endinterface

// File: rtl/fod_ctrl.sv
// Fractional output divider controller.
// Runs on its own divided/delayed output edge. Every edge it computes the
// MMD ratio, retimer polarity and DTC delay code for the following edge from
// a fractional phase accumulator, closes a bang-bang phase-sync loop against
// the multiphase sampler result, and optionally adapts the DTC gain with a
// sign-sign LMS rule.
module fod_ctrl #(
   parameter int WI       = 6,
   parameter int WF       = 16,
   parameter int WF_PHASE = 24
) (
   input  logic       CLK,
   input  logic       NARST,
   fod_ctrl_if.slave  bus
);

   localparam int WFCW = WI + WF;       // FCW width
   localparam int WC   = 34;            // signed width of corr and of the accumulator sum
   localparam int WCY  = WC - WF;       // signed carry width
   localparam int WM   = WCY + 2;       // signed width of integer part + carry
   localparam int WK   = 16;            // DTC gain register, 10.6 format
   localparam int WKI  = 10;            // integer part of the DTC gain
   localparam int WP   = WF + WKI;      // residue * gain product width
   localparam int NCO_SHIFT = 5;        // 8G period -> 1G aux period ratio of 8, in 2^-21 units

   localparam logic [WF-1:0]          R_MID  = WF'(1) << (WF - 1);
   localparam logic signed [WM-1:0]   MMD_LO = WM'(4);
   localparam logic signed [WM-1:0]   MMD_HI = WM'((1 << WI) - 1);
   localparam logic signed [WK+1:0]   K_MAX  = (WK + 2)'((1 << WK) - 1);

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic [WF-1:0]       acc;
   logic [WF_PHASE-1:0] nco_phase_s;
   logic [WF_PHASE-1:0] nco_phase_d1;
   logic [WK-1:0]       kdtc;
   logic [WI-1:0]       mmd_dcw;
   logic                rt_dcw;
   logic [9:0]          dtc_dcw;

   // ------------------------------------------------------------------
   // Next-state terms
   // ------------------------------------------------------------------
   logic [2:0]           exp_seg;     // expected sampler segment of the previous edge
   logic [2:0]           err;         // two's complement -4..3
   logic [4:0]           ks;
   logic signed [WC-1:0] err_ext;
   logic signed [WC-1:0] corr;

   logic [WF-1:0]        f;
   logic signed [WC-1:0] sum;
   logic signed [WCY-1:0] carry;
   logic [WF-1:0]        acc_next;
   logic signed [WM-1:0] mmd_raw;
   logic [WI-1:0]        mmd_next;

   logic                 rt_next;
   logic [WF-1:0]        r;
   logic [9:0]           dtc_next;

   logic signed [6:0]    step_exp;
   logic [3:0]           step_sh;
   logic [WK-1:0]        step;
   logic                 lms_move;
   logic                 lms_up;
   logic signed [WK+1:0] kdtc_adj;
   logic [WK-1:0]        kdtc_next;

   // Phase error of the previous edge and the resulting accumulator correction
   always_comb begin
      // NOTE: every variable is assigned on every pass through the block, so no latch can be inferred.
      exp_seg = 3'((nco_phase_d1 + (WF_PHASE'(bus.PHASE_CTRL) << (WF_PHASE - 10)))
                   >> (WF_PHASE - 3));
      err     = bus.PHE - exp_seg;
      ks      = (bus.PCALI_KS > 5'd16) ? 5'd16 : bus.PCALI_KS;
      err_ext = signed'({{(WC - 3){err[2]}}, err});
      corr    = '0;
      if (bus.PCALI_EN) begin
         corr = -(err_ext <<< ks);
      end
   end

   // Fractional accumulator, MMD ratio and retimer/DTC residue
   always_comb begin
      f        = bus.DSM_EN ? bus.FCW_FOD[WF-1:0] : '0;
      sum      = signed'(WC'(acc)) + signed'(WC'(f)) + corr;
      // Upper bits of a two's complement sum are exactly floor(sum / 2^WF).
      carry    = signed'(sum[WC-1:WF]);
      acc_next = sum[WF-1:0];
      mmd_raw  = signed'(WM'(bus.FCW_FOD[WFCW-1:WF])) + WM'(carry);

      if (mmd_raw < MMD_LO) begin
         mmd_next = WI'(4);
      end else if (mmd_raw > MMD_HI) begin
         mmd_next = '1;
      end else begin
         mmd_next = mmd_raw[WI-1:0];
      end

      // With retiming, the MSB selects the opposite edge and the DTC only covers half a period.
      rt_next = 1'b0;
      r       = acc_next;
      if (bus.RT_EN) begin
         rt_next = acc_next[WF-1];
         r       = {1'b0, acc_next[WF-2:0]};
      end

      // A WF-bit residue times a 10-bit gain shifted down by WF never exceeds 1023, so no clip is needed.
      dtc_next = 10'((WP'(r) * WP'(kdtc[WK-1:WK-WKI])) >> WF);
   end

   // Sign-sign LMS update of the DTC gain
   always_comb begin
      step_exp = 7'sd6 + 7'(signed'(bus.KB));
      if (step_exp < 7'sd0) begin
         step_sh = 4'd0;
      end else if (step_exp > 7'sd15) begin
         step_sh = 4'd15;
      end else begin
         step_sh = step_exp[3:0];
      end
      step = WK'(1) << step_sh;

      // Gain too small leaves a residual error whose sign follows the residue's side of mid-scale.
      lms_move = (err != 3'd0) && (r != R_MID);
      lms_up   = (~err[2]) == (r > R_MID);
      kdtc_adj = lms_up ? signed'((WK + 2)'(kdtc)) + signed'((WK + 2)'(step))
                        : signed'((WK + 2)'(kdtc)) - signed'((WK + 2)'(step));

      if (!bus.DTCCALI_EN) begin
         kdtc_next = {bus.KDTCB_INIT, 6'b0};
      end else if (!lms_move) begin
         kdtc_next = kdtc;
      end else if (kdtc_adj < (WK + 2)'(0)) begin
         kdtc_next = '0;
      end else if (kdtc_adj > K_MAX) begin
         kdtc_next = '1;
      end else begin
         kdtc_next = kdtc_adj[WK-1:0];
      end
   end

   // One register stage: all state and all output words update together on each FOD edge
   always_ff @(posedge CLK or negedge NARST) begin
      if (!NARST) begin
         acc          <= '0;
         nco_phase_s  <= '0;
         nco_phase_d1 <= '0;
         kdtc         <= '0;
         mmd_dcw      <= WI'(8);
         rt_dcw       <= 1'b0;
         dtc_dcw      <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register sees the pre-edge value of the others.
         acc          <= acc_next;
         // The ideal NCO never sees the correction; it is the reference the loop steers towards.
         nco_phase_s  <= nco_phase_s + (WF_PHASE'(bus.FCW_FOD) << NCO_SHIFT);
         nco_phase_d1 <= nco_phase_s;
         kdtc         <= kdtc_next;
         mmd_dcw      <= mmd_next;
         rt_dcw       <= rt_next;
         dtc_dcw      <= dtc_next;
      end
   end

   assign bus.MMD_DCW   = mmd_dcw;
   assign bus.RT_DCW    = rt_dcw;
   assign bus.DTC_DCW   = dtc_dcw;
   assign bus.NCO_PHASE = nco_phase_s;

endmodule

// File: tb/tb_fod_ctrl.sv
// Self-checking bench for fod_ctrl: directed scenarios with hand-computed
// values, then randomized control inputs, all outputs compared every cycle
// against an arithmetic model of the controller.
module tb_fod_ctrl;

   logic CLK   = 1'b0;
   logic NARST = 1'b1;

   fod_ctrl_if bus ();

   fod_ctrl dut (
      .CLK   (CLK),
      .NARST (NARST),
      .bus   (bus)
   );

   always #5 CLK = ~CLK;

   int n_chk  = 0;
   int n_pass = 0;
   bit chk_en = 1'b0;

   // Model state: values the DUT must hold after the most recent CLK edge
   longint m_acc, m_nco, m_d1, m_kdtc;
   int     m_mmd, m_rt, m_dtc;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   task automatic model_reset();
      m_acc = 0; m_nco = 0; m_d1 = 0; m_kdtc = 0;
      m_mmd = 8; m_rt = 0; m_dtc = 0;
   endtask

   // Expected 3-bit sampler segment for the previous edge
   function automatic int exp_top();
      return int'(((m_d1 + longint'(bus.PHASE_CTRL) * 16384) % 16777216) / 2097152);
   endfunction

   // Advance the model by one CLK edge using the inputs currently applied
   task automatic model_update();
      longint f, corr, sum, a, carry, r, mmd, step, k;
      int     e, ks, sh;
      if (!NARST) begin
         model_reset();
      end else begin
         e = ((int'(bus.PHE) - exp_top()) % 8 + 8) % 8;
         if (e > 3) e -= 8;
         ks    = (bus.PCALI_KS > 16) ? 16 : int'(bus.PCALI_KS);
         corr  = bus.PCALI_EN ? -(longint'(e) * (longint'(1) << ks)) : 0;
         f     = bus.DSM_EN ? longint'(bus.FCW_FOD) % 65536 : 0;
         sum   = m_acc + f + corr;
         a     = ((sum % 65536) + 65536) % 65536;
         carry = (sum - a) / 65536;
         mmd   = longint'(bus.FCW_FOD) / 65536 + carry;
         if (mmd < 4) mmd = 4;
         if (mmd > 63) mmd = 63;
         r     = bus.RT_EN ? a % 32768 : a;
         m_rt  = bus.RT_EN ? int'(a / 32768) : 0;
         m_dtc = int'((r * (m_kdtc / 64)) / 65536);
         if (m_dtc > 1023) m_dtc = 1023;
         if (!bus.DTCCALI_EN) begin
            k = longint'(bus.KDTCB_INIT) * 64;
         end else begin
            sh = 6 + int'($signed(bus.KB));
            if (sh < 0) sh = 0;
            if (sh > 15) sh = 15;
            step = longint'(1) << sh;
            k = m_kdtc;
            if (e != 0 && r != 32768)
               k = k + step * ((e > 0) ? 1 : -1) * ((r > 32768) ? 1 : -1);
            if (k < 0) k = 0;
            if (k > 65535) k = 65535;
         end
         m_mmd  = int'(mmd);
         m_d1   = m_nco;
         m_nco  = (m_nco + longint'(bus.FCW_FOD) * 32) % 16777216;
         m_acc  = a;
         m_kdtc = k;
      end
   endtask

   // Compare process: outputs are stable mid-cycle
   always @(negedge CLK) begin
      if (chk_en) begin
         check("mmd_dcw",   bus.MMD_DCW,   64'(m_mmd));
         check("rt_dcw",    bus.RT_DCW,    64'(m_rt));
         check("dtc_dcw",   bus.DTC_DCW,   64'(m_dtc));
         check("nco_phase", bus.NCO_PHASE, 64'(m_nco));
      end
   end

   // One FOD edge; returns 1 time unit after the following falling edge
   task automatic step();
      model_update();
      @(posedge CLK);
      @(negedge CLK);
      #1;
   endtask

   task automatic set_defaults();
      bus.DSM_EN     = 1'b1;
      bus.FCW_FOD    = 22'h40000;
      bus.PHE        = 3'd0;
      bus.PCALI_EN   = 1'b0;
      bus.PCALI_KS   = 5'd0;
      bus.PHASE_CTRL = 10'd0;
      bus.RT_EN      = 1'b0;
      bus.DTCCALI_EN = 1'b0;
      bus.KB         = 5'd0;
      bus.KDTCB_INIT = 10'd390;
   endtask

   // Asynchronous reset pulse spanning one edge; reset values must appear at once
   task automatic do_reset();
      NARST = 1'b0;
      model_reset();
      chk_en = 1'b1;
      #1;
      check("rst_mmd", bus.MMD_DCW,   64'd8);
      check("rst_rt",  bus.RT_DCW,    64'd0);
      check("rst_dtc", bus.DTC_DCW,   64'd0);
      check("rst_nco", bus.NCO_PHASE, 64'd0);
      step();
      NARST = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int exp_dtc_a[4];
      int exp_mmd_a[4];
      int exp_rt_b[4];
      int exp_dtc_b[4];
      int mmd_sum;
      logic [23:0] nco_before;

      exp_dtc_a = '{195, 292, 0, 97};
      exp_mmd_a = '{4, 4, 5, 4};
      exp_rt_b  = '{1, 1, 0, 0};
      exp_dtc_b = '{0, 97, 0, 97};

      set_defaults();
      #1;

      // FCW 4.5 with retiming: ratio alternates 4/5, polarity 1/0, residue always 0
      bus.FCW_FOD = 22'h48000;
      bus.RT_EN   = 1'b1;
      do_reset();
      for (int n = 1; n <= 6; n++) begin
         step();
         check("fcw45_mmd", bus.MMD_DCW, (n % 2 == 1) ? 64'd4 : 64'd5);
         check("fcw45_rt",  bus.RT_DCW,  (n % 2 == 1) ? 64'd1 : 64'd0);
         check("fcw45_dtc", bus.DTC_DCW, 64'd0);
      end

      // FCW 4.25 without retiming: acc 0x4000 steps, gain 390
      set_defaults();
      bus.FCW_FOD = 22'h44000;
      do_reset();
      step();
      for (int n = 0; n < 4; n++) begin
         step();
         check("fcw425_dtc", bus.DTC_DCW, 64'(exp_dtc_a[n]));
         check("fcw425_mmd", bus.MMD_DCW, 64'(exp_mmd_a[n]));
      end

      // Same FCW with retiming
      bus.RT_EN = 1'b1;
      do_reset();
      step();
      for (int n = 0; n < 4; n++) begin
         step();
         check("fcw425_rt_rt",  bus.RT_DCW,  64'(exp_rt_b[n]));
         check("fcw425_rt_dtc", bus.DTC_DCW, 64'(exp_dtc_b[n]));
      end

      // Integer-N then fractional: FCW 4.72
      set_defaults();
      bus.FCW_FOD = 22'h4B852;
      bus.DSM_EN  = 1'b0;
      do_reset();
      for (int n = 0; n < 8; n++) begin
         step();
         check("intn_mmd", bus.MMD_DCW, 64'd4);
         check("intn_dtc", bus.DTC_DCW, 64'd0);
      end
      bus.DSM_EN = 1'b1;
      mmd_sum = 0;
      for (int n = 0; n < 25; n++) begin
         step();
         mmd_sum += int'(bus.MMD_DCW);
      end
      check("frac_mmd_sum25", 64'(mmd_sum), 64'd118);

      // Phase-sync loop: PHE one segment ahead pulls acc down by 256 per edge
      set_defaults();
      bus.FCW_FOD = 22'h50000;
      bus.DSM_EN  = 1'b0;
      do_reset();
      step();
      step();
      bus.PCALI_EN = 1'b1;
      bus.PCALI_KS = 5'd8;
      bus.PHE = 3'((exp_top() + 1) % 8);
      step();
      check("psync1_mmd", bus.MMD_DCW, 64'd4);
      check("psync1_dtc", bus.DTC_DCW, 64'd388);
      bus.PHE = 3'((exp_top() + 1) % 8);
      step();
      check("psync2_mmd", bus.MMD_DCW, 64'd5);
      check("psync2_dtc", bus.DTC_DCW, 64'd386);
      bus.PHE = 3'(exp_top());
      step();
      check("psync_lock_dtc", bus.DTC_DCW, 64'd386);

      // NCO increment is independent of the correction
      bus.FCW_FOD = 22'h4A000;
      for (int n = 0; n < 4; n++) begin
         bus.PHE    = 3'($urandom);
         nco_before = bus.NCO_PHASE;
         step();
         check("nco_incr", 64'(24'(bus.NCO_PHASE - nco_before)), 64'h940000);
      end

      // DTC gain LMS: acc parked at 0xC000, err forced +1, KB=-3 -> +8 per edge
      set_defaults();
      bus.FCW_FOD = 22'h44000;
      do_reset();
      step(); step(); step();
      bus.DSM_EN     = 1'b0;
      bus.DTCCALI_EN = 1'b1;
      bus.KB         = 5'b11101;
      for (int n = 1; n <= 9; n++) begin
         bus.PHE = 3'((exp_top() + 1) % 8);
         step();
         if (n == 8) check("lms_gain390_dtc", bus.DTC_DCW, 64'd292);
         if (n == 9) check("lms_gain391_dtc", bus.DTC_DCW, 64'd293);
      end
      // Saturation at 0xFFFF (KB=15 clamps to a 2^15 step), then at 0
      bus.KB = 5'd15;
      for (int n = 0; n < 4; n++) begin
         bus.PHE = 3'((exp_top() + 1) % 8);
         step();
      end
      check("lms_sat_hi_dtc", bus.DTC_DCW, 64'd767);
      for (int n = 0; n < 4; n++) begin
         bus.PHE = 3'((exp_top() + 7) % 8);
         step();
      end
      check("lms_sat_lo_dtc", bus.DTC_DCW, 64'd0);

      // Randomized operation with occasional mid-run resets
      set_defaults();
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 49) == 0) bus.DTCCALI_EN = ~bus.DTCCALI_EN;
         bus.DSM_EN     = ($urandom_range(0, 9) != 0);
         bus.FCW_FOD    = {6'(($urandom_range(0, 9) == 0) ? $urandom_range(0, 63)
                                                          : $urandom_range(3, 9)),
                           16'($urandom)};
         bus.PCALI_EN   = 1'($urandom);
         bus.PCALI_KS   = 5'($urandom);
         bus.PHASE_CTRL = 10'($urandom);
         bus.RT_EN      = 1'($urandom);
         bus.KB         = 5'($urandom);
         bus.KDTCB_INIT = 10'($urandom);
         bus.PHE        = ($urandom_range(0, 3) == 0) ? 3'(exp_top()) : 3'($urandom);
         if ($urandom_range(0, 299) == 0) do_reset();
         else step();
      end

      chk_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
